// File: rtl/mem_pkg.sv
// Shared types and constants for the multicycle memory responder.
package mem_pkg;

  // Responder FSM state encoding
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  // Width of the word index carried by a byte address (adr[31:2])
  localparam int unsigned WORD_IDX_W = 30;

  // Default number of wait states between acceptance and response
  localparam int unsigned DEFAULT_WAIT_CYCLES = 2;

  // True when the access is misaligned or beyond the last stored word
  function automatic logic adr_bad(input logic [31:0] adr, input int unsigned depth);
    return (adr[1:0] != 2'b00) || ({2'b00, adr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word-addressed 32-bit RAM: synchronous write, combinational read.
// Byte enables exist only when MEM_RESPONDER_BYTE_EN_EN is defined.
module mem_array #(
  parameter int unsigned DEPTH_WORDS = 64,
  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
`ifdef MEM_RESPONDER_BYTE_EN_EN
  input  logic [3:0]    be,
`endif
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Storage update; contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (we) begin
`ifdef MEM_RESPONDER_BYTE_EN_EN
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
`else
      mem[addr] <= wdata;
`endif
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Multicycle memory responder: accepts one request, waits WAIT_CYCLES, then
// commits the access and pulses ready for one cycle (err flags bad addresses).
// Optional byte-enable write port: define MEM_RESPONDER_BYTE_EN_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        memwrite,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
`ifdef MEM_RESPONDER_BYTE_EN_EN
  input  logic [3:0]  be,
`endif
  output logic [31:0] readdata,
  output logic        ready,
  output logic        err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             commit;

  // Latched request
  logic [AW-1:0]    word_q;
  logic             bad_q;
  logic             write_q;
  logic [31:0]      wdata_q;

  // Request view used for the commit: live inputs in IDLE (zero-wait case
  // commits on the accept edge), latched copies otherwise
  logic [AW-1:0]    acc_word;
  logic             acc_bad;
  logic             acc_write;
  logic [31:0]      acc_wdata;

  logic [31:0]      ram_rdata;
  logic             ram_we;

`ifdef MEM_RESPONDER_BYTE_EN_EN
  logic [3:0]       be_q;
  logic [3:0]       acc_be;
`endif

  // Select between live request and latched request
  always_comb begin
    if (state_q == IDLE) begin
      acc_word  = adr[AW+1:2];
      acc_bad   = adr_bad(adr, DEPTH_WORDS);
      acc_write = memwrite;
      acc_wdata = writedata;
`ifdef MEM_RESPONDER_BYTE_EN_EN
      acc_be    = be;
`endif
    end else begin
      acc_word  = word_q;
      acc_bad   = bad_q;
      acc_write = write_q;
      acc_wdata = wdata_q;
`ifdef MEM_RESPONDER_BYTE_EN_EN
      acc_be    = be_q;
`endif
    end
  end

  // Next-state and wait counter; commit marks the edge entering RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d = CNT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ram_we = commit & acc_write & ~acc_bad;

  // State and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latch, loaded only when a request is accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q  <= '0;
      bad_q   <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= '0;
`ifdef MEM_RESPONDER_BYTE_EN_EN
      be_q    <= '0;
`endif
    end else if (state_q == IDLE && req) begin
      word_q  <= adr[AW+1:2];
      bad_q   <= adr_bad(adr, DEPTH_WORDS);
      write_q <= memwrite;
      wdata_q <= writedata;
`ifdef MEM_RESPONDER_BYTE_EN_EN
      be_q    <= be;
`endif
    end
  end

  // Registered response; readdata and err are zero outside the ready pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready    <= 1'b0;
      err      <= 1'b0;
      readdata <= '0;
    end else begin
      ready    <= commit;
      err      <= commit & acc_bad;
      readdata <= (commit && !acc_write && !acc_bad) ? ram_rdata : '0;
    end
  end

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem_array (
    .clk  (clk),
    .we   (ram_we),
    .addr (acc_word),
    .wdata(acc_wdata),
`ifdef MEM_RESPONDER_BYTE_EN_EN
    .be   (acc_be),
`endif
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: two instances (2 and 0 wait states)
// checked every cycle against an edge-counting behavioural model.
`timescale 1ns/1ps
module tb_mem_responder;

  localparam int unsigned DEPTH = 64;

  int unsigned wc [2] = '{2, 0};

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req;
  logic [1:0]  memwrite;
  logic [1:0]  ready;
  logic [1:0]  err;
  logic [31:0] adr       [2];
  logic [31:0] writedata [2];
  logic [31:0] readdata  [2];
  logic [3:0]  be_s      [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req[0]),
    .memwrite (memwrite[0]),
    .adr      (adr[0]),
    .writedata(writedata[0]),
`ifdef MEM_RESPONDER_BYTE_EN_EN
    .be       (be_s[0]),
`endif
    .readdata (readdata[0]),
    .ready    (ready[0]),
    .err      (err[0])
  );

  mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0), .CNT_W(4)) dut0 (
    .clk      (clk),
    .reset    (reset),
    .req      (req[1]),
    .memwrite (memwrite[1]),
    .adr      (adr[1]),
    .writedata(writedata[1]),
`ifdef MEM_RESPONDER_BYTE_EN_EN
    .be       (be_s[1]),
`endif
    .readdata (readdata[1]),
    .ready    (ready[1]),
    .err      (err[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Behavioural model: a request seen at edge e (when free) responds after
  // edge e+W; the next request can be taken no earlier than two edges later.
  logic [31:0] mmem [2][DEPTH];
  bit          m_busy [2];
  longint      m_resp [2];
  longint      m_free [2];
  bit          m_wr   [2];
  logic [31:0] m_adr  [2];
  logic [31:0] m_wd   [2];
  logic [3:0]  m_be   [2];
  logic        m_rdy  [2];
  logic        m_err  [2];
  logic [31:0] m_rd   [2];
  longint      ec = 0;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0;
      m_free[i] = 0;
    end
    forever begin
      @(posedge clk);
      ec++;
      for (int i = 0; i < 2; i++) begin
        m_rdy[i] = 1'b0;
        m_err[i] = 1'b0;
        m_rd[i]  = '0;
        if (!reset) begin
          m_busy[i] = 0;
        end else begin
          if (!m_busy[i] && ec >= m_free[i] && req[i]) begin
            m_busy[i] = 1;
            m_resp[i] = ec + longint'(wc[i]);
            m_wr[i]   = memwrite[i];
            m_adr[i]  = adr[i];
            m_wd[i]   = writedata[i];
            m_be[i]   = be_s[i];
          end
          if (m_busy[i] && ec == m_resp[i]) begin
            m_busy[i] = 0;
            m_free[i] = ec + 2;
            m_rdy[i]  = 1'b1;
            if (m_adr[i][1:0] != 2'b00 || m_adr[i][31:2] >= 30'(DEPTH)) begin
              m_err[i] = 1'b1;
            end else if (m_wr[i]) begin
`ifdef MEM_RESPONDER_BYTE_EN_EN
              for (int b = 0; b < 4; b++)
                if (m_be[i][b]) mmem[i][int'(m_adr[i][31:2])][8*b +: 8] = m_wd[i][8*b +: 8];
`else
              mmem[i][int'(m_adr[i][31:2])] = m_wd[i];
`endif
            end else begin
              m_rd[i] = mmem[i][int'(m_adr[i][31:2])];
            end
          end
        end
      end
      #2;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("ready%0d", i), 32'(ready[i]), 32'(m_rdy[i]));
        chk($sformatf("err%0d", i), 32'(err[i]), 32'(m_err[i]));
        chk($sformatf("readdata%0d", i), readdata[i], m_rd[i]);
      end
    end
  end

  // One transaction; lat = negedges from driving req to seeing ready
  task automatic xact(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, output logic [31:0] rd, output logic e,
                      output int lat);
    @(negedge clk);
    req[i] = 1'b1; memwrite[i] = wr; adr[i] = a; writedata[i] = d; be_s[i] = b;
    lat = 0; rd = '0; e = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ready[i]) begin
        lat = n; rd = readdata[i]; e = err[i];
        break;
      end
    end
    req[i] = 1'b0;
    if (lat == 0) begin
      total++; bad++;
      $display("FAIL timeout%0d: got no ready want ready within 40 cycles", i);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat, n1, n2, nr;
    logic [31:0] a;
    int          r, i;
    req = '0; memwrite = '0;
    for (int k = 0; k < 2; k++) begin
      adr[k] = '0; writedata[k] = '0; be_s[k] = 4'hF;
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Preload every word so all reads are defined
    for (int w = 0; w < int'(DEPTH); w++)
      for (int k = 0; k < 2; k++) xact(k, 1'b1, 32'(w * 4), $urandom, 4'hF, rd, e, lat);

    // Test 1: two wait states, write then read back
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat);
    chk("t1_lat", 32'(lat), 32'd3);
    chk("t1_err", 32'(e), 32'd0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, e, lat);
    chk("t1_rd", rd, 32'hDEADBEEF);

    // Test 2: zero wait states, req held high gives a repeat 2 cycles later
    xact(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat);
    @(negedge clk);
    req[1] = 1'b1; memwrite[1] = 1'b0; adr[1] = 32'h10;
    n1 = 0; n2 = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (ready[1]) begin n1 = n; rd = readdata[1]; break; end
    end
    chk("t2_lat", 32'(n1), 32'd1);
    chk("t2_rd", rd, 32'hDEADBEEF);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (ready[1]) begin n2 = n; break; end
    end
    req[1] = 1'b0;
    chk("t2_gap", 32'(n2), 32'd2);

    // Test 3: misaligned and out-of-range accesses
    xact(1, 1'b1, 32'h0, 32'h0000A5A5, 4'hF, rd, e, lat);
    xact(1, 1'b0, 32'h102, 32'h0, 4'hF, rd, e, lat);
    chk("t3_mis_err", 32'(e), 32'd1);
    chk("t3_mis_rd", rd, 32'h0);
    xact(1, 1'b1, 32'h100, 32'h55555555, 4'hF, rd, e, lat);
    chk("t3_oor_err", 32'(e), 32'd1);
    chk("t3_oor_rd", rd, 32'h0);
    xact(1, 1'b0, 32'h0, 32'h0, 4'hF, rd, e, lat);
    chk("t3_word0", rd, 32'h0000A5A5);

    // Test 4: reset during WAIT discards the write
    xact(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, rd, e, lat);
    @(negedge clk);
    req[0] = 1'b1; memwrite[0] = 1'b1; adr[0] = 32'h20; writedata[0] = 32'h12345678;
    @(negedge clk);
    reset = 1'b0; req[0] = 1'b0;
    @(negedge clk);
    chk("t4_rdy", 32'(ready[0]), 32'd0);
    reset = 1'b1;
    xact(0, 1'b0, 32'h20, 32'h0, 4'hF, rd, e, lat);
    chk("t4_rd", rd, 32'hCAFEF00D);

    // Test 6: input changes during WAIT are ignored
    xact(0, 1'b1, 32'h30, 32'h33333333, 4'hF, rd, e, lat);
    @(negedge clk);
    req[0] = 1'b1; memwrite[0] = 1'b0; adr[0] = 32'h10;
    nr = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (ready[0]) begin nr++; rd = readdata[0]; req[0] = 1'b0; end
      else if (n == 1) begin req[0] = 1'b0; adr[0] = 32'h30; memwrite[0] = 1'b1; end
      else if (n == 2) req[0] = 1'b1;
    end
    memwrite[0] = 1'b0;
    chk("t6_count", 32'(nr), 32'd1);
    chk("t6_rd", rd, 32'hDEADBEEF);
    xact(0, 1'b0, 32'h30, 32'h0, 4'hF, rd, e, lat);
    chk("t6_word12", rd, 32'h33333333);

`ifdef MEM_RESPONDER_BYTE_EN_EN
    // Test 5: byte-enabled partial write and no-op write
    xact(1, 1'b1, 32'h8, 32'hAABBCCDD, 4'hF, rd, e, lat);
    xact(1, 1'b1, 32'h8, 32'h11223344, 4'b0101, rd, e, lat);
    xact(1, 1'b0, 32'h8, 32'h0, 4'h0, rd, e, lat);
    chk("t5_rd", rd, 32'hAA22CC44);
    xact(1, 1'b1, 32'h8, 32'hFFFFFFFF, 4'h0, rd, e, lat);
    chk("t5_noop_err", 32'(e), 32'd0);
    xact(1, 1'b0, 32'h8, 32'h0, 4'h0, rd, e, lat);
    chk("t5_noop_rd", rd, 32'hAA22CC44);
`endif

    // Random traffic on both instances
    for (int k = 0; k < 200; k++) begin
      i = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      a = 32'($urandom_range(0, 63)) * 32'd4;
      if (r == 0) a = a | 32'($urandom_range(1, 3));
      if (r == 1) a = a + 32'h100;
      xact(i, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), rd, e, lat);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
